// File: rtl/faddsub_pipe.sv
// faddsub_pipe: pipelined float add/sub (operand reg, align, add+lzd, normalise/round) with valid/ready stream
module faddsub_pipe #(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23,
  localparam int W = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         ovf,
  output logic         nv
);
  localparam int M = FRAC_W + 1;
  localparam int A = FRAC_W + 3;
  localparam int S = FRAC_W + 5;
  localparam int LZW = $clog2(S);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  logic en;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  logic v0_q, s0_q;
  logic [W-1:0] a0_q, b0_q;
  always_ff @(posedge clk) begin
    if (!rstn) v0_q <= 1'b0;
    else if (en) v0_q <= in_valid;
    if (en) begin
      a0_q <= x1;
      b0_q <= x2;
      s0_q <= sub;
    end
  end
  logic sa, sb, swap, sl_d, st_d, a_nan, b_nan, a_inf, b_inf;
  logic [EXP_W-1:0] ea, eb, xa, xb, el_d, es, d;
  logic [FRAC_W-1:0] fa, fb;
  logic [M-1:0] ma, mb, ml_d, ms;
  logic [2*A-1:0] wide;
  logic [A-1:0] al_d;
  assign {sa, ea, fa} = a0_q;
  assign sb = b0_q[W-1] ^ s0_q;
  assign {eb, fb} = b0_q[W-2:0];
  assign xa = ea | EXP_W'(ea == '0);
  assign xb = eb | EXP_W'(eb == '0);
  assign ma = {|ea, fa};
  assign mb = {|eb, fb};
  assign swap = {eb, fb} > {ea, fa};
  assign el_d = swap ? xb : xa;
  assign es = swap ? xa : xb;
  assign ml_d = swap ? mb : ma;
  assign ms = swap ? ma : mb;
  assign sl_d = swap ? sb : sa;
  assign d = el_d - es;
  assign wide = {ms, 2'b00, {A{1'b0}}} >> d;
  assign al_d = 32'(d) >= A ? '0 : wide[2*A-1:A];
  assign st_d = 32'(d) >= A ? |ms : |wide[A-1:0];
  assign a_nan = &ea && |fa;
  assign b_nan = &eb && |fb;
  assign a_inf = &ea && fa == '0;
  assign b_inf = &eb && fb == '0;
  logic v1_q, sl1_q, sub1_q, st1_q, nan1_q, inv1_q, inf1_q, infs1_q;
  logic [EXP_W-1:0] el1_q;
  logic [M-1:0] ml1_q;
  logic [A-1:0] al1_q;
  always_ff @(posedge clk) begin
    if (!rstn) v1_q <= 1'b0;
    else if (en) v1_q <= v0_q;
    if (en) begin
      sl1_q <= sl_d;
      sub1_q <= sa ^ sb;
      el1_q <= el_d;
      ml1_q <= ml_d;
      al1_q <= al_d;
      st1_q <= st_d;
      nan1_q <= a_nan || b_nan;
      inv1_q <= a_inf && b_inf && (sa ^ sb);
      inf1_q <= a_inf || b_inf;
      infs1_q <= a_inf ? sa : sb;
    end
  end
  logic [S-1:0] sum_d;
  logic [LZW-1:0] lz_d;
  assign sum_d = sub1_q ? {1'b0, ml1_q, 3'b000} - {1'b0, al1_q, st1_q}
                        : {1'b0, ml1_q, 3'b000} + {1'b0, al1_q, st1_q};
  always_comb begin
    lz_d = '0;
    for (int i = 0; i < S; i++) if (sum_d[i]) lz_d = LZW'(S - 1 - i);
  end
  logic v2_q, sl2_q, zs2_q, nan2_q, inv2_q, inf2_q, infs2_q;
  logic [S-1:0] sum2_q;
  logic [LZW-1:0] lz2_q;
  logic [EXP_W-1:0] el2_q;
  always_ff @(posedge clk) begin
    if (!rstn) v2_q <= 1'b0;
    else if (en) v2_q <= v1_q;
    if (en) begin
      sl2_q <= sl1_q;
      zs2_q <= sl1_q && !sub1_q;
      sum2_q <= sum_d;
      lz2_q <= lz_d;
      el2_q <= el1_q;
      nan2_q <= nan1_q;
      inv2_q <= inv1_q;
      inf2_q <= inf1_q;
      infs2_q <= infs1_q;
    end
  end
  logic [S-1:0] norm;
  logic [FRAC_W-1:0] fr;
  logic cy, rnd, zero, big;
  logic signed [31:0] er;
  logic [W-1:0] y_d;
  logic ovf_d, nv_d;
  assign norm = sum2_q << lz2_q;
  assign zero = !norm[S-1];
  assign rnd = norm[S-M-1] && (|norm[S-M-2:0] || norm[S-M]);
  assign {cy, fr} = {1'b0, norm[S-2 -: FRAC_W]} + (FRAC_W+1)'(rnd);
  assign er = $signed(32'(el2_q)) + 1 - $signed(32'(lz2_q)) + $signed(32'(cy));
  assign big = er >= (1 << EXP_W) - 1;
  assign ovf_d = !nan2_q && !inv2_q && !inf2_q && !zero && big;
  assign nv_d = inv2_q && !nan2_q;
  assign y_d = nan2_q || inv2_q ? QNAN
             : inf2_q ? {infs2_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
             : zero ? {zs2_q, {(W-1){1'b0}}}
             : big ? {sl2_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
             : er <= 0 ? {sl2_q, {(W-1){1'b0}}}
             : {sl2_q, EXP_W'(er), fr};
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      y <= '0;
      ovf <= 1'b0;
      nv <= 1'b0;
    end else if (en) begin
      out_valid <= v2_q;
      y <= y_d;
      ovf <= ovf_d;
      nv <= nv_d;
    end
  end
endmodule

// File: doc/faddsub_pipe.md
FADDSUB_PIPE -- requirements
Module: faddsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width in bits.
REQ-002 SHALL have parameter FRAC_W, default 23, stored fraction width in bits; word width W = 1+EXP_W+FRAC_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port x1  input  W  first operand, IEEE-style {sign, exp, frac}.
REQ-008 SHALL have port x2  input  W  second operand.
REQ-009 SHALL have port sub  input  1  1 = compute x1-x2 (invert x2 sign), 0 = x1+x2.
REQ-010 SHALL have port out_valid  output  1  result present on y.
REQ-011 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port y  output  W  result.
REQ-013 SHALL have port ovf  output  1  result overflowed to infinity; qualified by out_valid.
REQ-014 SHALL have port nv  output  1  invalid operation (inf-inf); qualified by out_valid.

Function
REQ-015 SHALL be a 3-stage pipeline: S1 align (compare magnitudes, swap, right-shift smaller with sticky), S2 add/subtract plus leading-one detect, S3 normalise, round, exponent adjust, special-case select.
REQ-016 SHALL use one global advance enable en = !out_valid || out_ready; in_ready SHALL equal en; the pipeline SHALL hold all stage registers when en=0.
REQ-017 SHALL accept a transfer when in_valid && in_ready; accepted at edge k, result SHALL be on y with out_valid=1 after edge k+3 if en stayed 1, throughput one result per cycle.
REQ-018 SHALL propagate bubbles: stage valid bits shift with en; an empty stage SHALL not block advance.
REQ-019 SHALL keep y, ovf, nv stable while out_valid=1 and out_ready=0.
REQ-020 SHALL treat exponent 0 inputs as subnormal: effective exponent 1, hidden bit 0.
REQ-021 SHALL carry guard bit plus sticky (OR of all bits shifted past guard) through alignment; shift amounts >= FRAC_W+3 SHALL yield zero aligned fraction with sticky = OR of source fraction.
REQ-022 SHALL round to nearest, ties to even; rounding carry-out SHALL renormalise and increment exponent.
REQ-023 SHALL, on biased result exponent >= 2^EXP_W-1, output signed infinity and ovf=1.
REQ-024 SHALL, on biased result exponent <= 0, flush to zero with sign of larger-magnitude operand; no subnormal outputs.
REQ-025 SHALL output +0 for exact cancellation (equal magnitudes, opposite effective signs).
REQ-026 SHALL output canonical quiet NaN {0, all-ones exp, frac MSB=1, rest 0} when either operand is NaN; nv=0 for NaN input.
REQ-027 SHALL output canonical quiet NaN with nv=1 for inf + (-inf) after sub applied.
REQ-028 SHALL output the infinity operand unchanged (sign after sub) when exactly one operand is infinite or both equal-signed; ovf=0.
REQ-029 SHALL give the larger magnitude (ties: x1) the result sign, matching compare on {exp,frac}.

Reset
REQ-030 SHALL, while rstn=0 at a clock edge, clear all stage valid bits; out_valid=0, y=0, ovf=0, nv=0 after that edge; in_ready=1 the cycle after.
REQ-031 SHALL discard in-flight operations on reset mid-operation; no result for them SHALL ever appear.

Verification (EXP_W=8, FRAC_W=23)
REQ-032 x1=0x3F800000, x2=0x3F800000, sub=0 -> y=0x40000000, ovf=0, nv=0, out_valid 3 cycles after acceptance.
REQ-033 x1=0x3F800000, x2=0x3F800000, sub=1 -> y=0x00000000; x1=0x3F800000, x2=0x33800000, sub=0 -> y=0x3F800000 (tie to even).
REQ-034 x1=0x7F7FFFFF, x2=0x7F7FFFFF, sub=0 -> y=0x7F800000, ovf=1.
REQ-035 x1=0x7F800000, x2=0x7F800000, sub=1 -> y=0x7FC00000, nv=1; x1=0x7FC00000, x2=0x3F800000 -> y=0x7FC00000, nv=0.
REQ-036 stream 5 ops with out_ready=0 from cycle 2 -> in_ready=0 once out_valid=1, y stable, no op lost/duplicated after out_ready=1, results in order.
REQ-037 assert rstn=0 for one edge with 3 ops in flight -> out_valid=0 next cycle, no stale result emerges afterward.
